// File: rtl/if_stage_fifo_if.sv
//------------------------------------------------------------------------------
// Module  : if_stage_fifo_if
// Brief   : Fetch-stage bundle: redirect input, instruction SRAM port and
//           decode-side valid/allowin handshake.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_fifo_if #(
  parameter int CNT_W = 3
);
  logic             br_taken;
  logic [31:0]      br_target;
  logic             id_allowin;
  logic             inst_sram_en;
  logic [3:0]       inst_sram_we;
  logic [31:0]      inst_sram_addr;
  logic [31:0]      inst_sram_wdata;
  logic [31:0]      inst_sram_rdata;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic [CNT_W-1:0] buf_count;

  // Fetch stage side
  modport master (
    input  br_taken, br_target, id_allowin, inst_sram_rdata,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output id_valid, id_inst, id_pc, buf_count
  );

  // Decode / SRAM environment side
  modport slave (
    output br_taken, br_target, id_allowin, inst_sram_rdata,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  id_valid, id_inst, id_pc, buf_count
  );
endinterface

`default_nettype wire

// File: rtl/if_stage_fifo.sv
//------------------------------------------------------------------------------
// Module  : if_stage_fifo
// Brief   : Instruction-fetch stage. Issues sequential reads to a 1-cycle
//           latency SRAM, buffers {inst, pc} in a DEPTH-entry FIFO and hands
//           the head to decode. Redirect flushes FIFO and in-flight read.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_stage_fifo #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  wire logic      clk,
  input  wire logic      reset,
  if_stage_fifo_if.master bus
);

  localparam int               PTR_W       = $clog2(DEPTH);
  localparam logic [CNT_W:0]   c_DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_FULL      = CNT_W'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_pc;
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_target;
  logic [31:0]      w_addr;
  logic [CNT_W:0]   w_occ;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_id_valid;
  logic             w_unused;

  // Low address bits of the redirect target are dropped on purpose.
  assign w_unused   = ^bus.br_target[1:0];

  assign w_target   = {bus.br_target[31:2], 2'b00};
  assign w_addr     = bus.br_taken ? w_target : r_fetch_pc;

  // Occupancy counts the in-flight read as already buffered; a same-cycle
  // pop is deliberately not credited so the FIFO can never overflow.
  assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rsp_valid};
  assign w_issue    = !reset && (bus.br_taken || (w_occ < c_DEPTH_EXT));

  // The response landing in a redirect cycle belongs to the old stream.
  assign w_push     = r_rsp_valid && !bus.br_taken;
  assign w_id_valid = !reset && (r_count != '0) && !bus.br_taken;
  assign w_pop      = w_id_valid && bus.id_allowin;

  assign bus.inst_sram_en    = w_issue;
  assign bus.inst_sram_we    = 4'b0000;
  assign bus.inst_sram_addr  = w_addr;
  assign bus.inst_sram_wdata = 32'h0000_0000;

  assign bus.id_valid  = w_id_valid;
  assign bus.id_inst   = r_mem[r_rd_ptr][63:32];
  assign bus.id_pc     = r_mem[r_rd_ptr][31:0];
  assign bus.buf_count = reset ? '0 : r_count;

  // Next sequential fetch address; a redirect always reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_issue || bus.br_taken) begin
      r_fetch_pc <= w_addr + 32'd4;
    end
  end

  // Track the read issued this cycle so its data can be tagged next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_pc    <= RESET_PC;
    end else begin
      r_rsp_valid <= w_issue;
      r_rsp_pc    <= w_addr;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.inst_sram_rdata, r_rsp_pc};
    end
  end

  // FIFO pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || bus.br_taken) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A push into a full buffer would mean the issue throttle is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == c_FULL)));

endmodule

`default_nettype wire

// File: doc/if_stage_fifo.md
Name: if_stage_fifo

Overview:
Parametrised instruction-fetch stage. It issues sequential fetches to a synchronous instruction SRAM with one-cycle read latency, and buffers returned {inst, pc} pairs in a DEPTH-entry FIFO. It presents the FIFO head to the decode stage under a valid/allowin handshake. Decode back-pressure stalls fetch without dropping instructions, and a redirect from decode flushes the FIFO and cancels any in-flight read.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetch after reset
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
br_taken  input  1  redirect pulse from decode; valid for one cycle
br_target  input  32  redirect address; bits [1:0] are ignored and forced to 0
id_allowin  input  1  decode accepts the head entry this cycle
inst_sram_en  output  1  read request this cycle
inst_sram_we  output  4  tied to 4'b0
inst_sram_addr  output  32  read address
inst_sram_wdata  output  32  tied to 32'b0
inst_sram_rdata  input  32  read data for the request issued in the previous cycle
id_valid  output  1  head entry valid toward decode
id_inst  output  32  head instruction
id_pc  output  32  head PC
buf_count  output  CNT_W  current FIFO occupancy

Behaviour:
- State:
  - fetch_pc (32 bits)
  - rsp_valid and rsp_pc, tracking the in-flight read
  - FIFO storage of DEPTH x 64 bits
  - read pointer, write pointer and count; pointers are log2(DEPTH) bits and wrap modulo DEPTH
- Reset (synchronous, reset=1 at a clock edge): fetch_pc=RESET_PC, rsp_valid=0, pointers=0, count=0.
  - While reset is high: inst_sram_en=0, id_valid=0, buf_count=0.
  - Reset asserted mid-operation discards all FIFO contents and any in-flight read.
- Issue rule, evaluated combinationally each cycle:
  - issue = !reset && (br_taken || (count + rsp_valid) < DEPTH).
  - A pop in the same cycle is not credited. This is intentionally conservative and guarantees the FIFO never overflows.
- Address selection:
  - inst_sram_addr = br_taken ? {br_target[31:2],2'b00} : fetch_pc.
  - inst_sram_en = issue.
- Address update on issue: fetch_pc <= inst_sram_addr + 4, wrapping at 2^32.
  - Without issue: fetch_pc holds, except when br_taken is high, where fetch_pc <= target + 4 still applies.
- Response tracking: rsp_valid <= issue; rsp_pc <= inst_sram_addr.
- Push: when rsp_valid && !br_taken, write {inst_sram_rdata, rsp_pc} at the write pointer.
- Flush: when br_taken is high, read/write pointers and count reset to 0.
  - The response arriving in the same cycle is discarded (no push).
  - The redirect fetch is issued in the same cycle.
- Decode interface:
  - id_valid = (count != 0) && !br_taken.
  - id_inst and id_pc are the head entry.
  - Pop when id_valid && id_allowin.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Boundary conditions:
  - Push into a full FIFO is impossible by the issue rule; assert this in simulation.
  - Pop from an empty FIFO is impossible because id_valid=0.
  - A pointer at DEPTH-1 wraps to 0.
- Latency: request issued in cycle N -> entry pushed at end of cycle N+1 -> id_valid in cycle N+2 if the FIFO was empty.
  - First fetch after reset releases: cycle 0 addr=RESET_PC; id_valid=1 with id_pc=RESET_PC in cycle 2.
- Steady state with id_allowin=1: one instruction per cycle, PCs consecutive (+4).
- Stall: with id_allowin=0, issue stops once count+rsp_valid reaches DEPTH.
  - Fetch resumes in the cycle after the first pop makes room.
  - No instruction is lost or duplicated, and order is preserved.
- buf_count = count.

Test Plan:
- Reset release, RESET_PC=0x1c000000, id_allowin=1, SRAM returns addr^0xA5A5A5A5 -> cycle 0 en=1 addr=0x1c000000; cycle 2 id_valid=1, id_pc=0x1c000000; then one entry per cycle with PCs 0x1c000004, 0x1c000008, ... and matching data.
- Hold id_allowin=0 for 10 cycles after the first valid -> buf_count saturates at 4, inst_sram_en=0 once count+rsp_valid=4; on release, PCs continue gapless in order, no duplicates.
- br_taken=1 with br_target=0x1c000103 while count=3 and a read is in flight -> that cycle id_valid=0 and addr=0x1c000100; next cycle buf_count=0; two cycles later id_pc=0x1c000100, followed by 0x1c000104.
- br_taken while the FIFO is full and id_allowin=0 -> redirect fetch still issued the same cycle; old entries never appear on id_pc.
- Assert reset for one cycle mid-stream with count=2 -> buf_count=0, id_valid=0, and fetching restarts at 0x1c000000 after release.
- Random id_allowin (50%) plus random redirects, 10k cycles -> scoreboard confirms every delivered pc/inst pair matches the expected program-order stream since the last redirect, and the no-overflow assertion never fires.
